// File: rtl/ff_pkg.sv
// Shared types and default parameters for the stepped flip-flop bank.
package ff_pkg;

    typedef enum logic [1:0] {
        MODE_D    = 2'b00,
        MODE_JK   = 2'b01,
        MODE_T    = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam int DEF_WIDTH           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/step_debouncer.sv
// Synchronises and debounces the step button, emitting one strobe per press.
module step_debouncer
    import ff_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic Clock50M,
    input  logic reset,
    input  logic rawclock,
    output logic step_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync;
    logic          clean;
    logic          clean_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clock50M) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync  <= 1'b0;
        end else begin
            sync1 <= rawclock;
            sync  <= sync1;
        end
    end

    // Any return to the settled level restarts the hold count from zero.
    always_ff @(posedge Clock50M) begin
        if (reset) begin
            clean <= 1'b0;
            cnt   <= '0;
        end else if (sync == clean) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            clean <= sync;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock50M) begin
        if (reset) begin
            clean_d    <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            clean_d    <= clean;
            step_pulse <= clean & ~clean_d;
        end
    end

endmodule

// File: rtl/ff_bank.sv
// Bank of D/JK/T flip-flops advanced by a debounced push-button step.
module ff_bank
    import ff_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             Clock50M,
    input  logic             reset,
    input  logic             rawclock,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] dorjort,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             step_pulse,
    output logic [CNT_W-1:0] step_count
);

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_next;

    assign mode_sel = mode_e'(mode);
    assign q_bar    = ~q;

    step_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .Clock50M  (Clock50M),
        .reset     (reset),
        .rawclock  (rawclock),
        .step_pulse(step_pulse)
    );

    // JK: set where j, clear where k, both toggles, neither holds.
    always_comb begin
        q_next = q;
        unique case (mode_sel)
            MODE_D:    q_next = dorjort;
            MODE_JK:   q_next = (dorjort & ~q) | (~k & q);
            MODE_T:    q_next = q ^ dorjort;
            MODE_HOLD: q_next = q;
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge Clock50M) begin
        if (reset) begin
            q          <= '0;
            step_count <= '0;
        end else if (step_pulse) begin
            q          <= q_next;
            step_count <= step_count + 1'b1;
        end
    end

endmodule
